icache_assoc: RTL and testbench

//  Parametrised N-way set-associative blocking instruction cache; successor to the fixed 2-way/128-set/8-word I-cache.

---
 rtl/icache_pkg.sv | 30 +++
 rtl/icache_if.sv | 34 +++
 rtl/icache_way.sv | 46 ++++
 rtl/icache_assoc.sv | 203 ++++++++++++++++++++
 tb/tb_icache_assoc.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REFILL,
        S_RESP
    } state_t;

    // Byte-offset width within a line (word select plus the two byte bits).
    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets, input int line_words);
        return 32 - idx_w(sets) - off_w(line_words);
    endfunction

    // Extracts 'width' bits of 'addr' starting at bit 'lsb', right-justified.
    function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch, invalidate and bridge read-channel signals of the instruction cache.
// slave: the cache's view; master: the fetch stage plus read bridge.
interface icache_if #(
    parameter int IDX_W = 7
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic             req_uncached;
    logic             resp_valid;
    logic [31:0]      resp_data;
    logic             inv_valid;
    logic             inv_ready;
    logic [IDX_W-1:0] inv_index;
    logic             rd_req;
    logic             rd_rdy;
    logic [31:0]      rd_addr;
    logic [7:0]       rd_len;
    logic             ret_valid;
    logic             ret_last;
    logic [31:0]      ret_data;

    modport slave (
        input  req_valid, req_addr, req_uncached, inv_valid, inv_index,
               rd_rdy, ret_valid, ret_last, ret_data,
        output req_ready, resp_valid, resp_data, inv_ready, rd_req, rd_addr, rd_len
    );

    modport master (
        output req_valid, req_addr, req_uncached, inv_valid, inv_index,
               rd_rdy, ret_valid, ret_last, ret_data,
        input  req_ready, resp_valid, resp_data, inv_ready, rd_req, rd_addr, rd_len
    );
endinterface

// File: rtl/icache_way.sv
// One cache way: tag RAM plus one data bank per line word, shared write
// enable, synchronous read of the whole line at rd_idx.
module icache_way #(
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8,
    parameter int TAG_W      = 20
) (
    input  logic                          clk,
    input  logic [$clog2(SETS)-1:0]       rd_idx,
    input  logic                          we,
    input  logic [$clog2(SETS)-1:0]       wr_idx,
    input  logic [TAG_W-1:0]              wr_tag,
    input  logic [LINE_WORDS-1:0][31:0]   wr_line,
    output logic [TAG_W-1:0]              rd_tag,
    output logic [LINE_WORDS-1:0][31:0]   rd_line
);
    logic [TAG_W-1:0] tag_mem [SETS];
    logic [TAG_W-1:0] tag_q;

    // Tag RAM: write on fill, registered read every cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx] <= wr_tag;
        end
        tag_q <= tag_mem[rd_idx];
    end

    assign rd_tag = tag_q;

    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_bank
            logic [31:0] data_mem [SETS];
            logic [31:0] data_q;

            // Data bank for word gi of each line.
            always_ff @(posedge clk) begin
                if (we) begin
                    data_mem[wr_idx] <= wr_line[gi];
                end
                data_q <= data_mem[rd_idx];
            end

            assign rd_line[gi] = data_q;
        end
    endgenerate
endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative blocking instruction cache with uncached fetch,
// per-set invalidate and round-robin replacement preferring invalid ways.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8
) (
    input logic     clk,
    input logic     rst,
    icache_if.slave bus
);
    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(SETS, LINE_WORDS);
    localparam int WORD_W = OFF_W - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t                              state_q, state_d;
    logic [31:0]                         addr_q, addr_d;
    logic                                unc_q, unc_d;
    logic [WORD_W-1:0]                   beat_q, beat_d;
    logic [LINE_WORDS-1:0][31:0]         line_q, line_d;
    logic [31:0]                         word_q, word_d;
    logic [SETS-1:0][WAYS-1:0]           valid_q, valid_d;
    logic [SETS-1:0][WAY_W-1:0]          rr_q, rr_d;

    logic [IDX_W-1:0]                    req_idx, cur_idx;
    logic [TAG_W-1:0]                    cur_tag;
    logic [WORD_W-1:0]                   cur_word, last_beat;
    logic [WAYS-1:0][TAG_W-1:0]          way_tag;
    logic [WAYS-1:0][LINE_WORDS-1:0][31:0] way_line;
    logic [WAYS-1:0]                     hit_vec;
    logic [31:0]                         hit_word;
    logic [WAY_W-1:0]                    victim, rr_next;
    logic [LINE_WORDS-1:0][31:0]         fill_line;
    logic                                fill_we;

    assign req_idx   = IDX_W'(addr_field(bus.req_addr, OFF_W, IDX_W));
    assign cur_idx   = IDX_W'(addr_field(addr_q, OFF_W, IDX_W));
    assign cur_tag   = TAG_W'(addr_field(addr_q, OFF_W + IDX_W, TAG_W));
    assign cur_word  = WORD_W'(addr_field(addr_q, 2, WORD_W));
    assign last_beat = unc_q ? '0 : '1;
    assign fill_we   = (state_q == S_REFILL) && bus.ret_valid && bus.ret_last && !unc_q;
    assign rr_next   = (rr_q[cur_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[cur_idx] + 1'b1;

    assign bus.rd_addr = unc_q ? addr_q : {addr_q[31:OFF_W], OFF_W'(0)};
    assign bus.rd_len  = unc_q ? 8'd0 : 8'(LINE_WORDS - 1);

    // RAMs always read the incoming request's set so LOOKUP sees it a cycle later.
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            icache_way #(
                .SETS       (SETS),
                .LINE_WORDS (LINE_WORDS),
                .TAG_W      (TAG_W)
            ) u_way (
                .clk     (clk),
                .rd_idx  (req_idx),
                .we      (fill_we && (victim == WAY_W'(gi))),
                .wr_idx  (cur_idx),
                .wr_tag  (cur_tag),
                .wr_line (fill_line),
                .rd_tag  (way_tag[gi]),
                .rd_line (way_line[gi])
            );
        end
    endgenerate

    // Tag compare across ways; data is OR-muxed since at most one way hits.
    always_comb begin
        hit_vec  = '0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[cur_idx][w] && (way_tag[w] == cur_tag)) begin
                hit_vec[w] = 1'b1;
                hit_word   = hit_word | way_line[w][cur_word];
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the set's round-robin pointer.
    always_comb begin
        victim = rr_q[cur_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[cur_idx][w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    // Line written on the final beat: buffered beats with the last beat merged in.
    always_comb begin
        fill_line = line_q;
        fill_line[beat_q] = bus.ret_data;
    end

    // Next-state and output decode for the fetch FSM.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        unc_d          = unc_q;
        beat_d         = beat_q;
        line_d         = line_q;
        word_d         = word_q;
        valid_d        = valid_q;
        rr_d           = rr_q;
        bus.req_ready  = 1'b0;
        bus.inv_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.rd_req     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bus.inv_ready = 1'b1;
                if (bus.inv_valid) begin
                    valid_d[bus.inv_index] = '0;
                end else begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid) begin
                        addr_d  = bus.req_addr;
                        unc_d   = bus.req_uncached;
                        state_d = bus.req_uncached ? S_MISS : S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                if (|hit_vec) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_data  = hit_word;
                    bus.req_ready  = 1'b1;
                    if (bus.req_valid) begin
                        addr_d  = bus.req_addr;
                        unc_d   = bus.req_uncached;
                        state_d = bus.req_uncached ? S_MISS : S_LOOKUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                bus.rd_req = 1'b1;
                if (bus.rd_rdy) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (bus.ret_valid) begin
                    line_d[beat_q] = bus.ret_data;
                    beat_d         = beat_q + 1'b1;
                    if (bus.ret_last) begin
                        beat_d = '0;
                        if (unc_q) begin
                            word_d = bus.ret_data;
                        end else begin
                            valid_d[cur_idx][victim] = 1'b1;
                            rr_d[cur_idx]            = rr_next;
                        end
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = unc_q ? word_q : line_q[cur_word];
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, request latch, refill buffer, valid bits and RR pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            unc_q   <= 1'b0;
            beat_q  <= '0;
            line_q  <= '0;
            word_q  <= '0;
            valid_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            unc_q   <= unc_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

    a_single_hit: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_LOOKUP) |-> $onehot0(hit_vec));

    a_beat_count: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_REFILL && bus.ret_valid && bus.ret_last) |-> (beat_q == last_beat));
endmodule

// File: tb/tb_icache_assoc.sv
// Directed plus randomized bench for icache_assoc against a tag-level model.
module tb_icache_assoc;
    localparam int WAYS       = 2;
    localparam int SETS       = 128;
    localparam int LINE_WORDS = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bit          m_valid [SETS][WAYS];
    logic [19:0] m_tag   [SETS][WAYS];
    int          m_rr    [SETS];

    icache_if #(.IDX_W(7)) bus ();

    icache_assoc #(
        .WAYS       (WAYS),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Backing memory contents seen through the read bridge.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if ((a & 32'hFFFF_FFE0) == 32'h1C00_0040) return 32'hA0 + {29'd0, a[4:2]};
        if (a == 32'h1FAF_0000) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a, input logic u);
        if (u) return 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[a[11:5]][w] && m_tag[a[11:5]][w] == a[31:12]) return 1'b1;
        return 1'b0;
    endfunction

    // Allocate a line: first invalid way, else the set's rotating pointer, which advances on every fill.
    task automatic model_fill(input logic [31:0] a);
        int s;
        int v;
        s = int'(a[11:5]);
        v = m_rr[s];
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = a[31:12];
        m_rr[s]       = (m_rr[s] + 1) % WAYS;
    endtask

    task automatic wait_rd();
        int n;
        n = 0;
        while (bus.rd_req !== 1'b1 && n < 6) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rd_req_seen", 32'(bus.rd_req), 32'd1);
    endtask

    // One fetch; hit or miss behaviour is predicted by the model. obs_hit = response right after acceptance.
    task automatic fetch(input logic [31:0] a, input logic u, output logic obs_hit);
        bit          hit;
        int          stall;
        int          beats;
        logic [31:0] base;
        hit = model_hit(a, u);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_addr     = a;
        bus.req_uncached = u;
        #1 chk("req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_uncached = 1'b0;
        #1;
        obs_hit = bus.resp_valid;
        if (hit) begin
            chk("hit_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("hit_resp_data", bus.resp_data, mem_word(a));
            chk("hit_no_rd_req", 32'(bus.rd_req), 32'd0);
        end else begin
            chk("miss_no_early_resp", 32'(bus.resp_valid), 32'd0);
            wait_rd();
            base = u ? a : {a[31:5], 5'd0};
            chk("rd_addr", bus.rd_addr, base);
            chk("rd_len", 32'(bus.rd_len), u ? 32'd0 : 32'(LINE_WORDS - 1));
            stall = $urandom_range(0, 2);
            for (int s = 0; s < stall; s++) begin
                bus.ret_valid = 1'b1;
                bus.ret_data  = $urandom;
                bus.ret_last  = 1'($urandom_range(0, 1));
                @(negedge clk);
                #1;
                chk("rd_req_held", 32'(bus.rd_req), 32'd1);
                chk("inv_blocked_in_miss", 32'(bus.inv_ready), 32'd0);
            end
            bus.ret_valid = 1'b0;
            bus.ret_last  = 1'b0;
            bus.rd_rdy    = 1'b1;
            @(negedge clk);
            bus.rd_rdy = 1'b0;
            beats = u ? 1 : LINE_WORDS;
            for (int i = 0; i < beats; i++) begin
                bus.ret_valid = 1'b0;
                bus.ret_last  = 1'b0;
                repeat ($urandom_range(0, 1)) @(negedge clk);
                bus.ret_valid = 1'b1;
                bus.ret_data  = mem_word(base + 32'(4 * i));
                bus.ret_last  = (i == beats - 1);
                @(negedge clk);
            end
            bus.ret_valid = 1'b0;
            bus.ret_last  = 1'b0;
            #1;
            chk("miss_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("miss_resp_data", bus.resp_data, mem_word(a));
            if (!u) model_fill(a);
        end
    endtask

    task automatic do_inv(input int idx, input logic with_req);
        @(negedge clk);
        bus.inv_valid = 1'b1;
        bus.inv_index = 7'(idx);
        bus.req_valid = with_req;
        bus.req_addr  = {20'd0, 7'(idx), 5'd0};
        #1;
        chk("inv_ready", 32'(bus.inv_ready), 32'd1);
        chk("req_ready_during_inv", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.inv_valid = 1'b0;
        bus.req_valid = 1'b0;
        for (int w = 0; w < WAYS; w++) m_valid[idx][w] = 1'b0;
        #1;
        chk("inv_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("inv_stays_idle", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic        h;
        logic [31:0] a;
        int          r;
        total = 0;
        bad   = 0;
        model_reset();
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_uncached = 1'b0;
        bus.inv_valid    = 1'b0;
        bus.inv_index    = '0;
        bus.rd_rdy       = 1'b0;
        bus.ret_valid    = 1'b0;
        bus.ret_last     = 1'b0;
        bus.ret_data     = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_inv_ready", 32'(bus.inv_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rd_req", 32'(bus.rd_req), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        rst = 1'b0;

        // 1: cold cached fetch, line of 0xA0..0xA7.
        fetch(32'h1C00_0040, 1'b0, h);
        chk("t1_cold_miss", 32'(h), 32'd0);

        // 2: back-to-back hits on the same line.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h1C00_0044;
        #1 chk("t2_ready0", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_addr = 32'h1C00_0048;
        #1;
        chk("t2_resp0_valid", 32'(bus.resp_valid), 32'd1);
        chk("t2_resp0_data", bus.resp_data, 32'hA1);
        chk("t2_ready1", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("t2_resp1_valid", 32'(bus.resp_valid), 32'd1);
        chk("t2_resp1_data", bus.resp_data, 32'hA2);
        chk("t2_no_rd_req", 32'(bus.rd_req), 32'd0);

        // 3: three tags into one set of a 2-way cache.
        fetch(32'h0000_10A0, 1'b0, h);
        fetch(32'h0000_20A0, 1'b0, h);
        fetch(32'h0000_30A0, 1'b0, h);
        fetch(32'h0000_20A4, 1'b0, h);
        chk("t3_tag2_hit", 32'(h), 32'd1);
        fetch(32'h0000_10A0, 1'b0, h);
        chk("t3_tag1_evicted", 32'(h), 32'd0);

        // 4: uncached single-word fetch, never allocated.
        fetch(32'h1FAF_0000, 1'b1, h);
        fetch(32'h1FAF_0000, 1'b1, h);
        chk("t4_uncached_refetch_miss", 32'(h), 32'd0);
        fetch(32'h1FAF_0000, 1'b0, h);
        chk("t4_no_allocation", 32'(h), 32'd0);

        // 5: invalidate wins over a simultaneous request.
        fetch(32'h0000_0040, 1'b0, h);
        fetch(32'h0000_0040, 1'b0, h);
        chk("t5_hit_before_inv", 32'(h), 32'd1);
        do_inv(2, 1'b1);
        fetch(32'h0000_0040, 1'b0, h);
        chk("t5_miss_after_inv", 32'(h), 32'd0);

        // 6: reset in the middle of a refill abandons the line.
        a = 32'h0040_0100;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        wait_rd();
        bus.rd_rdy = 1'b1;
        @(negedge clk);
        bus.rd_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.ret_valid = 1'b1;
            bus.ret_data  = mem_word(a + 32'(4 * i));
            @(negedge clk);
        end
        bus.ret_valid = 1'b0;
        rst           = 1'b1;
        #1;
        chk("t6_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t6_inv_ready", 32'(bus.inv_ready), 32'd1);
        chk("t6_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("t6_rd_req", 32'(bus.rd_req), 32'd0);
        chk("t6_resp_data", bus.resp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        fetch(a, 1'b0, h);
        chk("t6_refetch_miss", 32'(h), 32'd0);

        // Random mix of fetches and invalidates over a few sets and tags.
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                do_inv($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end else begin
                a = {20'($urandom_range(1, 4)), 7'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
                fetch(a, r == 1, h);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
